wb_burst_master: RTL

Wishbone B3 bus master that turns simple command/data streams into incrementing-burst cycles for the SDRAM controller's Wishbone slave port. It is the initiator end of that port: DMA engines and test harnesses issue an address, a length and a direction, and this block drives `cyc`/`stb`/`cti`, sequences addresses, and streams write data out and read data back. It sits in the `wb_clk_i` domain in front of the controller top.

---
 rtl/wb_burst_master.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B3 master turning command/data streams into incrementing bursts.
// Latency: Wishbone cycle starts 1 cycle after command accept (read) or after first write word is taken (write); done 1 cycle after final ack.
// Backpressure: cmd_ready only in IDLE; wdat_ready throttled by a one-word hold register; rdat has no backpressure.
//
// Ports:
//   wb_clk_i / wb_rst_i            clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_*      command stream (address, length in words, direction, byte enables)
//   wdat_valid/wdat_ready/wdat     write data stream
//   rdat_valid/rdat                read data, one-cycle pulse per word
//   done / err                     completion pulse / timeout-abort pulse
//   wb_*                           Wishbone B3 master port
//
// Optional feature: define WB_BURST_MASTER_TIMEOUT_EN to abort a cycle after TO_CYCLES stalled cycles.
module wb_burst_master #(
    parameter int AW        = 26,
    parameter int DW        = 32,
    parameter int LW        = 9,
    parameter int TO_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [LW-1:0]     cmd_len,
    input  logic              cmd_we,
    input  logic [DW/8-1:0]   cmd_sel,
    input  logic              wdat_valid,
    output logic              wdat_ready,
    input  logic [DW-1:0]     wdat,
    output logic              rdat_valid,
    output logic [DW-1:0]     rdat,
    output logic              done,
    output logic              err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic              wb_ack_i
);

    localparam int            SW        = DW / 8;
    localparam logic [AW-1:0] ADDR_STEP = AW'(SW);
    localparam logic [2:0]    CTI_CLASSIC = 3'b000;
    localparam logic [2:0]    CTI_INCR    = 3'b010;
    localparam logic [2:0]    CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            multi_q, multi_d;     // command has more than one beat
    logic [LW-1:0]   beats_q, beats_d;     // acks still outstanding
    logic [LW-1:0]   load_q, load_d;       // write words still to be accepted
    logic [DW-1:0]   hold_q, hold_d;       // write hold register, drives wb_dat_o
    logic            stb_q, stb_d;         // in WR this doubles as the hold-valid flag
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [2:0]      cti_q, cti_d;
    logic [DW-1:0]   rdat_q, rdat_d;
    logic            rvld_q, rvld_d;

    logic            ack_eff;
    logic            take;
    logic            wdat_ready_c;
    logic            busy;
    logic            timeout_hit;
    logic [LW-1:0]   len_eff;
    logic [LW-1:0]   beats_dec;
    logic [2:0]      cti_after_ack;
    logic            unused_ok;

    // An ack only counts while we are actually strobing.
    assign ack_eff      = wb_ack_i & stb_q;
    assign len_eff      = (cmd_len == '0) ? LW'(1) : cmd_len;
    assign beats_dec    = beats_q - LW'(1);
    assign busy         = (state_q == RD) || (state_q == WR);

    // CTI for the beat presented after this ack: the beat with one ack left is the last.
    assign cti_after_ack = !multi_q               ? CTI_CLASSIC :
                           (beats_dec == LW'(1))  ? CTI_END     : CTI_INCR;

    // The hold register can accept a word when empty or being drained this cycle.
    assign wdat_ready_c = (state_q == WR) && (load_q != '0) && (!stb_q || ack_eff);
    assign take         = wdat_ready_c & wdat_valid;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);

    logic [TW-1:0] to_q, to_d;
    logic          err_q, err_d;

    // Counts consecutive stalled strobe cycles; any ack or idle strobe clears it.
    assign timeout_hit = busy && stb_q && !wb_ack_i && (to_q == TW'(TO_CYCLES - 1));

    always_comb begin
        to_d  = '0;
        err_d = timeout_hit;
        if (busy && stb_q && !wb_ack_i) begin
            to_d = to_q + TW'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end

    assign err       = err_q;
    assign unused_ok = ^cmd_addr[1:0];
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
    assign unused_ok   = ^{cmd_addr[1:0], (TO_CYCLES == 0)};
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        multi_d = multi_q;
        beats_d = beats_q;
        load_d  = load_q;
        hold_d  = hold_q;
        stb_d   = stb_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        cti_d   = cti_q;
        rdat_d  = rdat_q;
        rvld_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = {cmd_addr[AW-1:2], 2'b00};
                    sel_d   = cmd_sel;
                    multi_d = (len_eff != LW'(1));
                    beats_d = len_eff;
                    load_d  = len_eff;
                    cti_d   = (len_eff != LW'(1)) ? CTI_INCR : CTI_CLASSIC;
                    if (cmd_we) begin
                        // Write cycle opens only once the first word is in the hold register.
                        state_d = WR;
                    end else begin
                        state_d = RD;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                    end
                end
            end

            RD: begin
                if (timeout_hit) begin
                    state_d = FIN;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                end else if (ack_eff) begin
                    rdat_d  = wb_dat_i;
                    rvld_d  = 1'b1;
                    addr_d  = addr_q + ADDR_STEP;
                    beats_d = beats_dec;
                    cti_d   = cti_after_ack;
                    if (beats_q == LW'(1)) begin
                        state_d = FIN;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                    end
                end
            end

            WR: begin
                if (timeout_hit) begin
                    // Abort discards the hold register and any words not yet loaded.
                    state_d = FIN;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                end else begin
                    if (ack_eff) begin
                        addr_d  = addr_q + ADDR_STEP;
                        beats_d = beats_dec;
                        cti_d   = cti_after_ack;
                        stb_d   = 1'b0;
                    end
                    // A take in the same cycle as an ack refills without a bubble.
                    if (take) begin
                        hold_d = wdat;
                        stb_d  = 1'b1;
                        cyc_d  = 1'b1;
                        we_d   = 1'b1;
                        load_d = load_q - LW'(1);
                    end
                    if (ack_eff && (beats_q == LW'(1))) begin
                        state_d = FIN;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        we_d    = 1'b0;
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            multi_q <= 1'b0;
            beats_q <= '0;
            load_q  <= '0;
            hold_q  <= '0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            cti_q   <= '0;
            rdat_q  <= '0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            multi_q <= multi_d;
            beats_q <= beats_d;
            load_q  <= load_d;
            hold_q  <= hold_d;
            stb_q   <= stb_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            cti_q   <= cti_d;
            rdat_q  <= rdat_d;
            rvld_q  <= rvld_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign wdat_ready = wdat_ready_c;
    assign rdat_valid = rvld_q;
    assign rdat       = rdat_q;
    assign done       = (state_q == FIN);
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = stb_q;
    assign wb_we_o    = we_q;
    assign wb_addr_o  = addr_q;
    assign wb_dat_o   = hold_q;
    assign wb_sel_o   = sel_q;
    assign wb_cti_o   = cti_q;

endmodule
